// File: rtl/trap_sequencer_if.sv
// Handshake bundle between commit/trap-state logic and the trap sequencer.
// The sequencer itself connects through the slave modport.
interface trap_sequencer_if #(
    parameter int unsigned N_IRQ = 4
) ();
    logic              exc_valid;
    logic [31:0]       exc_cause;
    logic [63:0]       exc_pc;
    logic [N_IRQ-1:0]  irq_pending;
    logic [N_IRQ-1:0]  irq_enable;
    logic [63:0]       commit_pc;
    logic              in_trap;
    logic              flush_ack;
    logic              exc_ack;
    logic              flush_req;
    logic              raise_valid;
    logic [31:0]       raise_cause;
    logic [63:0]       raise_epc;
    logic              redirect_valid;
    logic [63:0]       redirect_pc;
    logic              busy;

    modport slave (
        input  exc_valid, exc_cause, exc_pc, irq_pending, irq_enable, commit_pc, in_trap,
        input  flush_ack,
        output exc_ack, flush_req, raise_valid, raise_cause, raise_epc, redirect_valid,
        output redirect_pc, busy
    );

    modport master (
        output exc_valid, exc_cause, exc_pc, irq_pending, irq_enable, commit_pc, in_trap,
        output flush_ack,
        input  exc_ack, flush_req, raise_valid, raise_cause, raise_epc, redirect_valid,
        input  redirect_pc, busy
    );
endinterface

// File: rtl/trap_sequencer.sv
// Trap entry sequencer: accepts an exception or interrupt, flushes the pipeline,
// raises the trap to the trap state unit, then redirects fetch to the vector.
module trap_sequencer #(
    parameter int unsigned N_IRQ    = 4,
    parameter logic [63:0] VEC_BASE = 64'h0000_0000_0000_0100
) (
    input  logic             clk,
    input  logic             rst_n,
    trap_sequencer_if.slave  tsif
);

    localparam logic [31:0] DoubleFault = 32'h0000_00FF;

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StRaise,
        StRedirect
    } state_e;

    state_e      state_q;
    logic [31:0] cause_q;
    logic [63:0] epc_q;
    logic        flush_req_q;
    logic        raise_valid_q;
    logic [31:0] raise_cause_q;
    logic [63:0] raise_epc_q;
    logic        redirect_valid_q;
    logic [63:0] redirect_pc_q;
    logic        busy_q;

    logic [N_IRQ-1:0] irq_active;
    logic             irq_hit;
    logic [4:0]       irq_idx;
    logic [31:0]      exc_cause_sel;
    logic [63:0]      redirect_target;

    assign irq_active = tsif.irq_pending & tsif.irq_enable;

    // Descending scan so the lowest active index wins.
    always_comb begin
        irq_hit = 1'b0;
        irq_idx = '0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (irq_active[i]) begin
                irq_hit = 1'b1;
                irq_idx = 5'(i);
            end
        end
    end

    assign exc_cause_sel = tsif.in_trap ? DoubleFault : tsif.exc_cause;

    assign redirect_target = cause_q[31] ? VEC_BASE + {56'd0, cause_q[4:0], 3'b000} : VEC_BASE;

    // Ack is gated by rst_n so every output reads 0 while reset is held.
    assign tsif.exc_ack = rst_n && (state_q == StIdle) && tsif.exc_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            cause_q          <= '0;
            epc_q            <= '0;
            flush_req_q      <= 1'b0;
            raise_valid_q    <= 1'b0;
            raise_cause_q    <= '0;
            raise_epc_q      <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            busy_q           <= 1'b0;
        end else begin
            raise_valid_q    <= 1'b0;
            raise_cause_q    <= '0;
            raise_epc_q      <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            case (state_q)
                StIdle: begin
                    if (tsif.exc_valid) begin
                        cause_q     <= exc_cause_sel;
                        epc_q       <= tsif.exc_pc;
                        state_q     <= StFlush;
                        flush_req_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end else if (!tsif.in_trap && irq_hit) begin
                        cause_q     <= {27'h400_0000, irq_idx};
                        epc_q       <= tsif.commit_pc;
                        state_q     <= StFlush;
                        flush_req_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                StFlush: begin
                    if (tsif.flush_ack) begin
                        state_q       <= StRaise;
                        flush_req_q   <= 1'b0;
                        raise_valid_q <= 1'b1;
                        raise_cause_q <= cause_q;
                        raise_epc_q   <= epc_q;
                    end
                end
                StRaise: begin
                    state_q          <= StRedirect;
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= redirect_target;
                end
                StRedirect: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= StIdle;
                    flush_req_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign tsif.flush_req      = flush_req_q;
    assign tsif.raise_valid    = raise_valid_q;
    assign tsif.raise_cause    = raise_cause_q;
    assign tsif.raise_epc      = raise_epc_q;
    assign tsif.redirect_valid = redirect_valid_q;
    assign tsif.redirect_pc    = redirect_pc_q;
    assign tsif.busy           = busy_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios plus randomized
// trap requests checked against a behavioural model of trap entry.
module tb_trap_sequencer;

    localparam int unsigned N   = 4;
    localparam logic [63:0] VEC = 64'h0000_0000_0000_0100;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    trap_sequencer_if #(.N_IRQ(N)) bus ();

    trap_sequencer #(
        .N_IRQ    (N),
        .VEC_BASE (VEC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tsif  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {exc_ack, flush_req, raise_valid, raise_cause, raise_epc, redirect_valid, redirect_pc, busy}
    function automatic logic [164:0] obs();
        return {bus.exc_ack, bus.flush_req, bus.raise_valid, bus.raise_cause, bus.raise_epc,
                bus.redirect_valid, bus.redirect_pc, bus.busy};
    endfunction

    function automatic logic [164:0] mk(input logic ack, input logic fr, input logic rv,
                                        input logic [31:0] rc, input logic [63:0] re,
                                        input logic dv, input logic [63:0] dp, input logic bsy);
        return {ack, fr, rv, rc, re, dv, dp, bsy};
    endfunction

    // Reference: decide whether a trap is taken and what it raises and where it goes.
    function automatic void model(input logic ev, input logic [31:0] ec, input logic [63:0] ep,
                                  input logic [N-1:0] pend, input logic [N-1:0] en,
                                  input logic it, input logic [63:0] cpc,
                                  output logic taken, output logic [31:0] mc,
                                  output logic [63:0] me, output logic [63:0] mpc);
        int unsigned act;
        int unsigned lowbit;
        act   = 32'(pend & en);
        taken = 1'b0;
        mc    = '0;
        me    = '0;
        if (ev) begin
            taken = 1'b1;
            mc    = it ? 32'hFF : ec;
            me    = ep;
        end else if (!it && act != 0) begin
            lowbit = act & (~act + 1);
            taken  = 1'b1;
            mc     = 32'h8000_0000 + 32'($clog2(lowbit));
            me     = cpc;
        end
        mpc = mc[31] ? VEC + 64'(mc % 32) * 8 : VEC;
    endfunction

    task automatic clear_inputs();
        bus.exc_valid   = 1'b0;
        bus.exc_cause   = '0;
        bus.exc_pc      = '0;
        bus.irq_pending = '0;
        bus.irq_enable  = '0;
        bus.commit_pc   = '0;
        bus.in_trap     = 1'b0;
        bus.flush_ack   = 1'b0;
    endtask

    // Drive one request from IDLE and check every cycle through the return to IDLE.
    // With hold set, a second exception is held from cycle 1 and must be acked in cycle 4.
    task automatic run_seq(input string nm, input logic ev, input logic [31:0] ec,
                           input logic [63:0] ep, input logic [N-1:0] pend,
                           input logic [N-1:0] en, input logic it, input logic [63:0] cpc,
                           input int stall, input logic hold);
        logic        taken;
        logic [31:0] mc;
        logic [63:0] me;
        logic [63:0] mpc;
        logic [164:0] exp_v;
        model(ev, ec, ep, pend, en, it, cpc, taken, mc, me, mpc);
        @(posedge clk); #1;
        bus.exc_valid = ev; bus.exc_cause = ec; bus.exc_pc = ep;
        bus.irq_pending = pend; bus.irq_enable = en; bus.in_trap = it; bus.commit_pc = cpc;
        bus.flush_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        vectors++;
        exp_v = mk(ev, 0, 0, 0, 0, 0, 0, 0);
        if (obs() !== exp_v) begin
            miscompares++;
            $display("FAIL %s accept: got %h want %h", nm, obs(), exp_v);
        end
        if (!taken) begin
            @(posedge clk); #1;
            clear_inputs();
            @(negedge clk);
            vectors++;
            if (obs() !== mk(0, 0, 0, 0, 0, 0, 0, 0)) begin
                miscompares++;
                $display("FAIL %s idle: got %h want 0", nm, obs());
            end
            return;
        end
        for (int c = 0; c <= stall + 2; c++) begin
            @(posedge clk); #1;
            if (hold) begin
                bus.exc_valid = 1'b1; bus.exc_cause = 32'd7; bus.exc_pc = 64'h3000;
                bus.in_trap = 1'b0; bus.irq_pending = '0;
            end else if (c <= stall) begin
                bus.exc_valid = 1'($urandom_range(0, 1));
                bus.irq_pending = N'($urandom); bus.irq_enable = N'($urandom);
            end else begin
                clear_inputs();
            end
            bus.flush_ack = (c < stall) ? 1'b0 : (c == stall) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (c <= stall)          exp_v = mk(0, 1, 0, 0, 0, 0, 0, 1);
            else if (c == stall + 1) exp_v = mk(0, 0, 1, mc, me, 0, 0, 1);
            else                     exp_v = mk(0, 0, 0, 0, 0, 1, mpc, 1);
            vectors++;
            if (obs() !== exp_v) begin
                miscompares++;
                $display("FAIL %s seq cycle %0d: got %h want %h", nm, c + 1, obs(), exp_v);
            end
        end
        @(posedge clk); #1;
        if (!hold) clear_inputs();
        bus.flush_ack = 1'b0;
        @(negedge clk);
        vectors++;
        exp_v = mk(hold, 0, 0, 0, 0, 0, 0, 0);
        if (obs() !== exp_v) begin
            miscompares++;
            $display("FAIL %s back in idle: got %h want %h", nm, obs(), exp_v);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        bus.exc_valid = 1'b1; bus.exc_cause = 32'd2;
        bus.irq_pending = '1; bus.irq_enable = '1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (obs() !== mk(0, 0, 0, 0, 0, 0, 0, 0)) begin
                miscompares++;
                $display("FAIL reset hold: got %h want 0", obs());
            end
        end
        @(posedge clk); #1;
        clear_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_exception();
        run_seq("exception", 1, 32'd5, 64'h1000, '0, '0, 0, 64'h0, 0, 0);
    endtask

    task automatic test_irq_priority();
        run_seq("irq_priority", 0, 32'd0, 64'h0, 4'b1010, 4'b1111, 0, 64'h2000, 0, 0);
    endtask

    task automatic test_masking();
        run_seq("irq_masked", 0, 32'd0, 64'h0, 4'b0001, 4'b0000, 0, 64'h2000, 0, 0);
        run_seq("exc_over_irq", 1, 32'd11, 64'h5000, 4'b0100, 4'b1111, 0, 64'h6000, 1, 0);
        run_seq("irq_in_trap", 0, 32'd0, 64'h0, 4'b1111, 4'b1111, 1, 64'h2000, 0, 0);
    endtask

    task automatic test_double_fault();
        run_seq("double_fault", 1, 32'd3, 64'h1234, '0, '0, 1, 64'h0, 0, 0);
    endtask

    task automatic test_flush_stall();
        run_seq("flush_stall", 1, 32'd2, 64'h7000, '0, '0, 0, 64'h0, 10, 0);
    endtask

    task automatic test_back_to_back();
        logic [164:0] exp_v;
        run_seq("b2b_first", 1, 32'd1, 64'h100, '0, '0, 0, 64'h0, 0, 1);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            clear_inputs();
            bus.flush_ack = 1'b1;
            @(negedge clk);
            case (c)
                1:       exp_v = mk(0, 1, 0, 0, 0, 0, 0, 1);
                2:       exp_v = mk(0, 0, 1, 32'd7, 64'h3000, 0, 0, 1);
                3:       exp_v = mk(0, 0, 0, 0, 0, 1, VEC, 1);
                default: exp_v = mk(0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            vectors++;
            if (obs() !== exp_v) begin
                miscompares++;
                $display("FAIL b2b second cycle %0d: got %h want %h", c, obs(), exp_v);
            end
        end
    endtask

    task automatic test_reset_in_flush();
        @(posedge clk); #1;
        bus.exc_valid = 1'b1; bus.exc_cause = 32'd9; bus.exc_pc = 64'h4000; bus.flush_ack = 1'b0;
        @(posedge clk); #1;
        bus.exc_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.flush_req !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_flush pre: flush_req got %b want 1", bus.flush_req);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (obs() !== mk(0, 0, 0, 0, 0, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL rst_flush async: got %h want 0", obs());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_inputs();
        run_seq("after_reset", 1, 32'd4, 64'h8000, '0, '0, 0, 64'h0, 0, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            run_seq("random", 1'($urandom_range(0, 2) == 0), $urandom, {$urandom, $urandom},
                    N'($urandom), N'($urandom), 1'($urandom_range(0, 3) == 0),
                    {$urandom, $urandom}, int'($urandom_range(0, 3)), 0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        clear_inputs();
        test_reset();
        test_exception();
        test_irq_priority();
        test_masking();
        test_double_fault();
        test_flush_stall();
        test_back_to_back();
        test_reset_in_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 Parameter N_IRQ, default 4: number of interrupt lines (1..32).
REQ-002 Parameter VEC_BASE, default 64'h0000_0000_0000_0100: trap vector base address.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 exc_valid  in  1  synchronous exception request from commit; the source holds it until exc_ack.
REQ-006 exc_cause  in  32  exception cause, valid with exc_valid.
REQ-007 exc_pc  in  64  faulting PC, valid with exc_valid.
REQ-008 irq_pending  in  N_IRQ  level interrupt requests.
REQ-009 irq_enable  in  N_IRQ  per-line interrupt mask, where 1 means enabled.
REQ-010 commit_pc  in  64  PC of the next instruction to commit; used as the EPC for interrupts.
REQ-011 in_trap  in  1  trap-active status from the trap state unit.
REQ-012 flush_ack  in  1  pipeline flush complete.
REQ-013 exc_ack  out  1  exception accepted, one-cycle pulse.
REQ-014 flush_req  out  1  pipeline flush request.
REQ-015 raise_valid  out  1  trap-raise strobe to the trap state unit.
REQ-016 raise_cause  out  32  cause driven with raise_valid.
REQ-017 raise_epc  out  64  EPC driven with raise_valid.
REQ-018 redirect_valid  out  1  fetch redirect strobe.
REQ-019 redirect_pc  out  64  redirect target.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 The FSM SHALL have four states (IDLE, FLUSH, RAISE, REDIRECT) and SHALL hold a captured cause register and a captured EPC register.
REQ-022 In IDLE with exc_valid=1, the block SHALL capture exc_pc and a cause, drive exc_ack=1 combinationally in that cycle, and go to FLUSH.
  - Cause = exc_cause when in_trap=0.
  - Cause = 32'h0000_00FF (double fault) when in_trap=1.
REQ-023 In IDLE with exc_valid=0, in_trap=0 and (irq_pending & irq_enable)!=0, the block SHALL select the lowest-index active line i, capture cause 32'h8000_0000|i and EPC commit_pc, and go to FLUSH; no ack is given.
REQ-024 Exceptions SHALL take priority over interrupts on the same cycle; interrupts SHALL be ignored while in_trap=1.
REQ-025 Requests arriving outside IDLE SHALL be ignored and SHALL NOT be acked; a held exc_valid is accepted on the first cycle back in IDLE.
REQ-026 flush_req SHALL be 1 exactly while in FLUSH; flush_ack sampled high in FLUSH SHALL move the FSM to RAISE; flush_ack outside FLUSH SHALL be ignored; FLUSH has no timeout.
REQ-027 In RAISE, raise_valid SHALL be 1 for exactly one cycle, with raise_cause and raise_epc equal to the captured values; next state is REDIRECT.
REQ-028 In REDIRECT, redirect_valid SHALL be 1 for exactly one cycle; next state is IDLE.
  - redirect_pc = VEC_BASE when cause[31]=0.
  - redirect_pc = VEC_BASE + {cause[4:0],3'b000}, zero-extended to 64 bits with no overflow detection, when cause[31]=1.
REQ-029 Outside their strobe state, raise_cause, raise_epc and redirect_pc SHALL be 0.
REQ-030 Latency SHALL be: accept at cycle 0; flush_req from cycle 1; if flush_ack=1 in cycle 1, raise_valid in cycle 2, redirect_valid in cycle 3, IDLE in cycle 4.
REQ-031 The block SHALL NOT sample irq_pending after capture; deassertion of irq_pending mid-sequence SHALL NOT abort the sequence.

Reset
REQ-032 While rst_n=0 (including mid-sequence), the FSM SHALL be in IDLE, the capture registers SHALL be 0, and all outputs SHALL be 0.
REQ-033 After rst_n deasserts, the first acceptance SHALL occur no earlier than the first rising edge with rst_n=1.

Verification
REQ-034 Exception: exc_valid=1, exc_cause=5, exc_pc=0x1000, in_trap=0, flush_ack tied 1 -> exc_ack in cycle 0; raise cause=5, epc=0x1000 in cycle 2; redirect_pc=0x100 in cycle 3.
REQ-035 IRQ priority: irq_pending=4'b1010, irq_enable=4'b1111, commit_pc=0x2000 -> raise cause=0x8000_0001, epc=0x2000; redirect_pc=0x108.
REQ-036 Masking and priority:
  - irq_pending=4'b0001, irq_enable=0 -> no activity, busy=0.
  - Same-cycle exc_valid and irq -> exception is taken.
  - in_trap=1 with irq only -> no activity.
REQ-037 Double fault: in_trap=1, exc_valid=1, exc_cause=3 -> raise_cause=0xFF, redirect_pc=0x100.
REQ-038 Flush stall: hold flush_ack=0 for 10 cycles -> flush_req stays 1 and raise_valid stays 0; raise_valid follows the cycle after flush_ack=1.
REQ-039 Reset in FLUSH: rst_n pulsed low -> all outputs 0 immediately; a new exception after release is accepted normally.
